alu_pipe: RTL and testbench

ALU_PIPE -- requirements
Module: alu_pipe

---
 rtl/alu_pipe.sv | 134 +++++++++++++
 tb/tb_alu_pipe.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_pipe.sv
// alu_pipe: two-stage valid/ready ALU (add, sub, bitwise ops) with carry/ovf/zero flags.
// Build option ALU_PIPE_SAT_EN: unsigned saturation of add/sub results.
module alu_pipe #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             ovf,
  output logic             zero
);

  localparam int MSB = WIDTH - 1;
`ifdef ALU_PIPE_SAT_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_OR   = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_XOR  = 3'b011;
  localparam logic [2:0] OP_XNOR = 3'b100;
  localparam logic [2:0] OP_NAND = 3'b101;
  localparam logic [2:0] OP_NOR  = 3'b110;
  localparam logic [2:0] OP_SUB  = 3'b111;

  logic             w_adv;
  logic             r_vld_p1;
  logic [WIDTH-1:0] r_a_p1;
  logic [WIDTH-1:0] r_b_p1;
  logic [2:0]       r_sel_p1;
  logic             r_vld_p2;
  logic [WIDTH-1:0] r_res_p2;
  logic             r_carry_p2;
  logic             r_ovf_p2;
  logic             r_zero_p2;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_diff;
  logic [WIDTH-1:0] w_res;
  logic             w_carry;
  logic             w_ovf;

  // A carry-out on add means the true sum exceeds all-ones.
  function automatic logic [WIDTH-1:0] sat_add(input logic [WIDTH-1:0] r, input logic c);
    return (SAT_EN && c) ? {WIDTH{1'b1}} : r;
  endfunction

  // No carry-out on a+~b+1 means a borrow, i.e. the true difference is negative.
  function automatic logic [WIDTH-1:0] sat_sub(input logic [WIDTH-1:0] r, input logic c);
    return (SAT_EN && !c) ? {WIDTH{1'b0}} : r;
  endfunction

  assign w_adv    = !r_vld_p2 || out_ready;
  assign in_ready = w_adv;

  // ---- stage 1: operand capture ----
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld_p1 <= 1'b0;
    end else if (w_adv) begin
      r_vld_p1 <= in_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (w_adv) begin
      r_a_p1   <= a;
      r_b_p1   <= b;
      r_sel_p1 <= sel;
    end
  end

  assign w_sum  = {1'b0, r_a_p1} + {1'b0, r_b_p1};
  assign w_diff = {1'b0, r_a_p1} + {1'b0, ~r_b_p1} + (WIDTH+1)'(1);

  always_comb begin
    w_res   = '0;
    w_carry = 1'b0;
    w_ovf   = 1'b0;
    case (r_sel_p1)
      OP_ADD: begin
        w_carry = w_sum[WIDTH];
        w_ovf   = (r_a_p1[MSB] == r_b_p1[MSB]) && (w_sum[MSB] != r_a_p1[MSB]);
        w_res   = sat_add(w_sum[MSB:0], w_sum[WIDTH]);
      end
      OP_OR:   w_res = r_a_p1 | r_b_p1;
      OP_AND:  w_res = r_a_p1 & r_b_p1;
      OP_XOR:  w_res = r_a_p1 ^ r_b_p1;
      OP_XNOR: w_res = ~(r_a_p1 ^ r_b_p1);
      OP_NAND: w_res = ~(r_a_p1 & r_b_p1);
      OP_NOR:  w_res = ~(r_a_p1 | r_b_p1);
      OP_SUB: begin
        w_carry = w_diff[WIDTH];
        w_ovf   = (r_a_p1[MSB] != r_b_p1[MSB]) && (w_diff[MSB] != r_a_p1[MSB]);
        w_res   = sat_sub(w_diff[MSB:0], w_diff[WIDTH]);
      end
      default: w_res = '0;
    endcase
  end

  // ---- stage 2: result and flag registers ----
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld_p2   <= 1'b0;
      r_res_p2   <= '0;
      r_carry_p2 <= 1'b0;
      r_ovf_p2   <= 1'b0;
      r_zero_p2  <= 1'b0;
    end else if (w_adv) begin
      r_vld_p2   <= r_vld_p1;
      r_res_p2   <= w_res;
      r_carry_p2 <= w_carry;
      r_ovf_p2   <= w_ovf;
      r_zero_p2  <= (w_res == '0);
    end
  end

  assign out_valid = r_vld_p2;
  assign result    = r_res_p2;
  assign carry     = r_carry_p2;
  assign ovf       = r_ovf_p2;
  assign zero      = r_zero_p2;

endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: directed vectors for alu_pipe (WIDTH=8) with a queue-based reference model
// checked on every output-valid cycle plus literal expected values.
module tb_alu_pipe;

  localparam int W = 8;
`ifdef ALU_PIPE_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic [2:0]   sel = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] result;
  logic         carry;
  logic         ovf;
  logic         zero;

  int n_tests = 0;
  int n_fail  = 0;
  bit checking = 1'b0;

  typedef struct {
    int r;
    bit c;
    bit o;
    bit z;
  } exp_t;
  exp_t q[$];

  alu_pipe #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .sel(sel), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .carry(carry), .ovf(ovf), .zero(zero)
  );

  always #5 clk = ~clk;

  // Reference: plain integer arithmetic on the operand values.
  function automatic void model(input int av, input int bv, input logic [2:0] op,
                                output int r, output bit c, output bit o, output bit z);
    int m, h, sa, sb, s;
    m = 1 << W;
    h = 1 << (W - 1);
    sa = (av >= h) ? av - m : av;
    sb = (bv >= h) ? bv - m : bv;
    c = 1'b0;
    o = 1'b0;
    r = 0;
    case (op)
      3'd0: begin
        s = av + bv;
        c = (s >= m);
        r = s % m;
        o = ((sa + sb) > h - 1) || ((sa + sb) < -h);
        if (SAT && c) r = m - 1;
      end
      3'd7: begin
        s = av - bv;
        c = (av >= bv);
        r = (s + m) % m;
        o = ((sa - sb) > h - 1) || ((sa - sb) < -h);
        if (SAT && !c) r = 0;
      end
      3'd1: r = av | bv;
      3'd2: r = av & bv;
      3'd3: r = av ^ bv;
      3'd4: r = ~(av ^ bv) & (m - 1);
      3'd5: r = ~(av & bv) & (m - 1);
      default: r = ~(av | bv) & (m - 1);
    endcase
    z = (r == 0);
  endfunction

  always @(posedge clk) begin
    exp_t e;
    if (rst) begin
      q.delete();
    end else begin
      if (out_valid && out_ready && q.size() > 0) q.delete(0);
      if (in_valid && in_ready) begin
        model(int'(a), int'(b), sel, e.r, e.c, e.o, e.z);
        q.push_back(e);
      end
    end
  end

  always @(negedge clk) begin
    #1;
    if (checking && !rst) begin
      n_tests++;
      if (in_ready !== (!out_valid || out_ready)) begin
        n_fail++;
        $display("FAIL in_ready_rule: in_ready=%0b out_valid=%0b out_ready=%0b", in_ready, out_valid, out_ready);
      end
      if (out_valid) begin
        n_tests++;
        if (q.size() == 0) begin
          n_fail++;
          $display("FAIL spurious_beat: out_valid=1 result=%0d with no beat outstanding", result);
        end else if (int'(result) != q[0].r || carry != q[0].c || ovf != q[0].o || zero != q[0].z) begin
          n_fail++;
          $display("FAIL model_cmp: got r=%0d c=%0b o=%0b z=%0b expected r=%0d c=%0b o=%0b z=%0b",
                   result, carry, ovf, zero, q[0].r, q[0].c, q[0].o, q[0].z);
        end
      end
    end
  end

  task automatic chk(input string nm, input int act, input int expv);
    n_tests++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, expv);
    end
  endtask

  task automatic single(input string nm, input logic [W-1:0] ta, input logic [W-1:0] tbv,
                        input logic [2:0] op, input int er, input bit ec, input bit eo, input bit ez);
    @(negedge clk);
    a = ta; b = tbv; sel = op; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk({nm, "_early"}, out_valid, 0);
    @(negedge clk);
    #1;
    chk({nm, "_valid"}, out_valid, 1);
    chk({nm, "_result"}, result, er);
    chk({nm, "_carry"}, carry, ec);
    chk({nm, "_ovf"}, ovf, eo);
    chk({nm, "_zero"}, zero, ez);
  endtask

  logic [W-1:0] ba[4];
  logic [W-1:0] bbv[4];
  logic [2:0]   bop[4];
  int           ber[4];
  logic [W-1:0] sa3[3];
  logic [W-1:0] sb3[3];
  logic [2:0]   sop3[3];
  int           ser[3];
  int           got[3];

  initial begin
    int idx, ngot, ov, rv;
    // reset
    repeat (2) @(negedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_result", result, 0);
    chk("rst_carry", carry, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_zero", zero, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", in_ready, 1);
    checking = 1'b1;

    // single beats with literal expectations
    single("add200_100", 8'd200, 8'd100, 3'b000, SAT ? 255 : 44, 1'b1, 1'b0, 1'b0);
    single("sub5_7", 8'd5, 8'd7, 3'b111, SAT ? 0 : 254, 1'b0, 1'b0, SAT);
    single("add127_1", 8'd127, 8'd1, 3'b000, 128, 1'b0, 1'b1, 1'b0);
    single("andF0_0F", 8'hF0, 8'h0F, 3'b010, 0, 1'b0, 1'b0, 1'b1);
    single("sub128_1", 8'h80, 8'h01, 3'b111, 127, 1'b1, 1'b1, 1'b0);
    single("xnorF0_CC", 8'hF0, 8'hCC, 3'b100, 8'hC3, 1'b0, 1'b0, 1'b0);
    single("orA0_05", 8'hA0, 8'h05, 3'b001, 8'hA5, 1'b0, 1'b0, 1'b0);

    // back-to-back xor, nand, nor, sub
    ba  = '{8'hAA, 8'hF0, 8'h0F, 8'h10};
    bbv = '{8'h0F, 8'h3C, 8'h30, 8'h01};
    bop = '{3'b011, 3'b101, 3'b110, 3'b111};
    ber = '{8'hA5, 8'hCF, 8'hC0, 8'h0F};
    out_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      ov = int'(out_valid);
      rv = int'(result);
      if (i < 4) begin
        a = ba[i]; b = bbv[i]; sel = bop[i]; in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      chk($sformatf("b2b_valid_%0d", i), ov, (i >= 2 && i <= 5) ? 1 : 0);
      if (i >= 2 && i <= 5) chk($sformatf("b2b_result_%0d", i), rv, ber[i-2]);
    end

    // stall: out_ready low for 5 cycles with 3 beats offered
    sa3  = '{8'd1, 8'hFF, 8'd9};
    sb3  = '{8'd2, 8'h0F, 8'd4};
    sop3 = '{3'b000, 3'b011, 3'b111};
    ser  = '{3, 8'hF0, 5};
    idx = 0;
    ngot = 0;
    out_ready = 1'b0;
    for (int cyc = 0; cyc < 25 && ngot < 3; cyc++) begin
      @(negedge clk);
      if (cyc == 5) out_ready = 1'b1;
      if (idx < 3) begin
        a = sa3[idx]; b = sb3[idx]; sel = sop3[idx]; in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (cyc >= 2 && cyc < 5) begin
        chk($sformatf("stall_in_ready_%0d", cyc), in_ready, 0);
        chk($sformatf("stall_valid_%0d", cyc), out_valid, 1);
        chk($sformatf("stall_hold_%0d", cyc), result, 3);
      end
      if (out_valid && out_ready) begin
        got[ngot] = int'(result);
        ngot++;
      end
      if (in_valid && in_ready) idx++;
    end
    in_valid = 1'b0;
    chk("stall_beats_out", ngot, 3);
    for (int i = 0; i < 3; i++) if (i < ngot) chk($sformatf("stall_order_%0d", i), got[i], ser[i]);

    // reset with beats in both stages
    @(negedge clk);
    out_ready = 1'b1;
    a = 8'd200; b = 8'd100; sel = 3'b000; in_valid = 1'b1;
    @(negedge clk);
    a = 8'd127; b = 8'd1;
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("pre_rst_valid", out_valid, 1);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_result", result, 0);
    chk("mid_rst_flags", {carry, ovf, zero}, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    ov = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1;
      if (out_valid) ov++;
    end
    chk("no_stale_beat", ov, 0);

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
